// File: rtl/decode_8b10b_sync_pkg.sv
// Shared constants, sync-state encoding and weight helper for the 8b/10b receive decoder.
package decode_8b10b_sync_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {LOS, ACQ, SYNC} sync_state_t;

  function automatic logic [2:0] weight(input logic [5:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/decode_8b10b_core.sv
// Combinational 10b -> {K, byte} lookup with code/disparity checks and next running disparity.
module decode_8b10b_core
  import decode_8b10b_sync_pkg::*;
(
  input  logic [9:0] sym,
  input  logic       rd_in,
  output logic [7:0] data,
  output logic       k,
  output logic       code_err,
  output logic       disp_err,
  output logic       comma,
  output logic       rd_out
);

  logic [5:0] s6;
  logic [3:0] s4;
  logic [2:0] w6, w4;
  logic [4:0] x;
  logic [2:0] y, y_fix;
  logic       v6, v4, p7, a7, k28, a7_d, a7_k, d6, d4, rd_mid;
  logic [7:0] byte_dec;

  // Sub-blocks as written on the wire: abcdei and fghj, first letter in the MSB.
  assign s6 = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
  assign s4 = {sym[6], sym[7], sym[8], sym[9]};
  assign w6 = weight(s6);
  assign w4 = weight({2'b00, s4});

  always_comb begin
    x  = '0;
    v6 = 1'b1;
    case (s6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110, 6'b001111,
      6'b110000:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              v6 = 1'b0;
    endcase
  end

  always_comb begin
    y  = '0;
    v4 = 1'b1;
    p7 = 1'b0;
    a7 = 1'b0;
    case (s4)
      4'b1011, 4'b0100: y = 3'd0;
      4'b1001:          y = 3'd1;
      4'b0101:          y = 3'd2;
      4'b1100, 4'b0011: y = 3'd3;
      4'b1101, 4'b0010: y = 3'd4;
      4'b1010:          y = 3'd5;
      4'b0110:          y = 3'd6;
      4'b1110, 4'b0001: begin y = 3'd7; p7 = 1'b1; end
      4'b0111, 4'b1000: begin y = 3'd7; a7 = 1'b1; end
      default:          v4 = 1'b0;
    endcase
  end

  assign k28  = (s6 == 6'b001111) || (s6 == 6'b110000);
  // Alternate-7 is only legal where the primary form would extend a run to five.
  assign a7_d = ((s4 == 4'b0111) && (s6 == 6'b100011 || s6 == 6'b010011 || s6 == 6'b001011)) ||
                ((s4 == 4'b1000) && (s6 == 6'b110100 || s6 == 6'b101100 || s6 == 6'b011100));
  assign a7_k = ((s4 == 4'b1000) && (s6 == 6'b111010 || s6 == 6'b110110 ||
                                     s6 == 6'b101110 || s6 == 6'b011110)) ||
                ((s4 == 4'b0111) && (s6 == 6'b000101 || s6 == 6'b001001 ||
                                     s6 == 6'b010001 || s6 == 6'b100001));

  assign code_err = !v6 || !v4 || (k28 && p7) || (a7 && !k28 && !a7_d && !a7_k);

  // After 110000 the balanced K28 4b forms swap meaning (x.1<->x.6, x.2<->x.5).
  always_comb begin
    y_fix = y;
    if (s6 == 6'b110000) begin
      case (s4)
        4'b1001: y_fix = 3'd6;
        4'b0110: y_fix = 3'd1;
        4'b0101: y_fix = 3'd5;
        4'b1010: y_fix = 3'd2;
        default: y_fix = y;
      endcase
    end
  end

  assign byte_dec = code_err ? 8'h00 : {y_fix, x};
  assign data     = byte_dec;
  assign k        = !code_err && (k28 || a7_k);
  assign comma    = k && (byte_dec == K28_1 || byte_dec == K28_5 || byte_dec == K28_7);

  always_comb begin
    d6     = 1'b0;
    rd_mid = rd_in;
    case (w6)
      3'd4: begin d6 = rd_in;  rd_mid = 1'b1; end
      3'd2: begin d6 = !rd_in; rd_mid = 1'b0; end
      3'd3: begin
        if (s6 == 6'b111000)      d6 = rd_in;
        else if (s6 == 6'b000111) d6 = !rd_in;
      end
      default: ;
    endcase
    d4     = 1'b0;
    rd_out = rd_mid;
    case (w4)
      3'd3: begin d4 = rd_mid;  rd_out = 1'b1; end
      3'd1: begin d4 = !rd_mid; rd_out = 1'b0; end
      3'd2: begin
        if (s4 == 4'b1100)      d4 = rd_mid;
        else if (s4 == 4'b0011) d4 = !rd_mid;
      end
      default: ;
    endcase
  end

  assign disp_err = (d6 || d4) && !code_err;

endmodule

// File: rtl/decode_8b10b_sync.sv
// 8b/10b receive decoder: one-cycle registered byte/flags, running disparity and comma-based word sync.
module decode_8b10b_sync
  import decode_8b10b_sync_pkg::*;
#(
  parameter bit          RD_INIT     = 1'b0,
  parameter int unsigned SYNC_COMMAS = 3,
  parameter int unsigned ERR_LIMIT   = 4,
  parameter int unsigned GOOD_RUN    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [9:0] in_data,
  output logic       out_valid,
  output logic [8:0] out_data,
  output logic       out_code_err,
  output logic       out_disp_err,
  output logic       out_comma,
  output logic       rd,
  output logic       sync
);

  localparam logic [3:0] SYNC_N = 4'(SYNC_COMMAS);
  localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);
  localparam logic [3:0] GOOD_N = 4'(GOOD_RUN);

  logic [7:0]  dec_data;
  logic        dec_k, dec_code_err, dec_disp_err, dec_comma, dec_rd, err;
  sync_state_t state, state_n;
  logic [3:0]  comma_cnt, comma_n, err_cnt, err_n, good_cnt, good_n;

  decode_8b10b_core u_core (
    .sym      (in_data),
    .rd_in    (rd),
    .data     (dec_data),
    .k        (dec_k),
    .code_err (dec_code_err),
    .disp_err (dec_disp_err),
    .comma    (dec_comma),
    .rd_out   (dec_rd)
  );

  assign err  = dec_code_err || dec_disp_err;
  assign sync = (state == SYNC);

  always_comb begin
    state_n = state;
    comma_n = comma_cnt;
    err_n   = err_cnt;
    good_n  = good_cnt;
    if (in_valid) begin
      case (state)
        LOS: begin
          if (dec_comma && !err) begin
            comma_n = 4'd1;
            if (SYNC_N == 4'd1) begin
              state_n = SYNC;
              err_n   = '0;
              good_n  = '0;
            end else begin
              state_n = ACQ;
            end
          end
        end
        ACQ: begin
          if (err) begin
            state_n = LOS;
            comma_n = '0;
          end else if (dec_comma) begin
            comma_n = comma_cnt + 4'd1;
            if (comma_n == SYNC_N) begin
              state_n = SYNC;
              err_n   = '0;
              good_n  = '0;
            end
          end
        end
        SYNC: begin
          if (err) begin
            err_n  = err_cnt + 4'd1;
            good_n = '0;
            if (err_n == ERR_N) begin
              state_n = LOS;
              comma_n = '0;
            end
          end else if (err_cnt != '0) begin
            good_n = good_cnt + 4'd1;
            if (good_n == GOOD_N) begin
              err_n  = err_cnt - 4'd1;
              good_n = '0;
            end
          end
        end
        default: state_n = LOS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_code_err <= 1'b0;
      out_disp_err <= 1'b0;
      out_comma    <= 1'b0;
      rd           <= RD_INIT;
      state        <= LOS;
      comma_cnt    <= '0;
      err_cnt      <= '0;
      good_cnt     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data     <= {dec_k, dec_data};
        out_code_err <= dec_code_err;
        out_disp_err <= dec_disp_err;
        out_comma    <= dec_comma;
        rd           <= dec_rd;
      end
      state     <= state_n;
      comma_cnt <= comma_n;
      err_cnt   <= err_n;
      good_cnt  <= good_n;
    end
  end

endmodule

// File: tb/tb_decode_8b10b_sync.sv
// Directed and table-sweep bench for decode_8b10b_sync, with an independent 8b/10b encoder model.
module tb_decode_8b10b_sync;

  logic       clk = 1'b0;
  logic       rst_n, in_valid;
  logic [9:0] in_data;
  logic       out_valid, out_code_err, out_disp_err, out_comma, rd, sync;
  logic [8:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit legal_sym [1024];
  bit set6 [64];
  bit set4 [16];

  always #5 clk = ~clk;

  decode_8b10b_sync #(
    .RD_INIT(1'b0), .SYNC_COMMAS(3), .ERR_LIMIT(4), .GOOD_RUN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_code_err(out_code_err),
    .out_disp_err(out_disp_err), .out_comma(out_comma), .rd(rd), .sync(sync)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {valid, code_err, disp_err, comma, rd, sync, data}
  function automatic logic [31:0] obs();
    return {17'd0, out_valid, out_code_err, out_disp_err, out_comma, rd, sync, out_data};
  endfunction

  function automatic logic [31:0] ex(input logic v, input logic ce, input logic de,
                                     input logic cm, input logic r, input logic s,
                                     input logic [8:0] d);
    return {17'd0, v, ce, de, cm, r, s, d};
  endfunction

  task automatic send(input logic [9:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] t6(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;  5'd2:  return 6'b101101;
      5'd3:  return 6'b110001;  5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;  5'd8:  return 6'b111001;
      5'd9:  return 6'b100101;  5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;  5'd14: return 6'b011100;
      5'd15: return 6'b010111;  5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;  5'd20: return 6'b001011;
      5'd21: return 6'b101010;  5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;  5'd26: return 6'b010110;
      5'd27: return 6'b110110;  5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  default: return 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] t4d(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011; 3'd1: return 4'b1001; 3'd2: return 4'b0101; 3'd3: return 4'b1100;
      3'd4: return 4'b1101; 3'd5: return 4'b1010; 3'd6: return 4'b0110; default: return 4'b1110;
    endcase
  endfunction

  function automatic logic [3:0] t4k(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011; 3'd1: return 4'b0110; 3'd2: return 4'b1010; 3'd3: return 4'b1100;
      3'd4: return 4'b1101; 3'd5: return 4'b0101; 3'd6: return 4'b1001; default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

  task automatic code_of(input int c, output logic k, output logic [7:0] b);
    if (c < 256) begin
      k = 1'b0;
      b = 8'(c);
    end else if (c < 264) begin
      k = 1'b1;
      b = {3'(c - 256), 5'd28};
    end else begin
      k = 1'b1;
      case (c)
        264: b = 8'hF7;
        265: b = 8'hFB;
        266: b = 8'hFD;
        default: b = 8'hFE;
      endcase
    end
  endtask

  task automatic encode(input logic k, input logic [7:0] b, input logic rdi,
                        output logic [9:0] sym, output logic rdo);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rdm;
    int         w6, w4;
    x  = b[4:0];
    y  = b[7:5];
    c6 = (k && x == 5'd28) ? 6'b001111 : t6(x);
    w6 = $countones(c6);
    if (rdi && (w6 != 3 || c6 == 6'b111000)) c6 = ~c6;
    rdm = (w6 == 3) ? rdi : !rdi;
    if (k) c4 = (x == 5'd28) ? t4k(y) : 4'b0111;
    else if (y == 3'd7)
      c4 = ((!rdm && (x == 17 || x == 18 || x == 20)) ||
            (rdm && (x == 11 || x == 13 || x == 14))) ? 4'b0111 : 4'b1110;
    else c4 = t4d(y);
    w4 = $countones(c4);
    if (rdm && (w4 != 2 || c4 == 4'b1100 || k)) c4 = ~c4;
    rdo = (w4 == 2) ? rdm : !rdm;
    sym = {rev4(c4), rev6(c6)};
  endtask

  initial begin
    logic       k, rdo, ill, a7f, p7f, k28f;
    logic [7:0] b;
    logic [9:0] sym;
    logic [5:0] s6;
    logic [3:0] s4;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check("reset", obs(), ex(0, 0, 0, 0, 0, 0, 9'h000));
    @(negedge clk);
    rst_n = 1'b1;

    send(10'h17C); check("k285_first",  obs(), ex(1, 0, 0, 1, 1, 0, 9'h1BC));
    send(10'h283); check("k285_rdp",    obs(), ex(1, 0, 0, 1, 0, 0, 9'h1BC));
    send(10'h17C); check("acq_to_sync", obs(), ex(1, 0, 0, 1, 1, 1, 9'h1BC));
    send(10'h283); check("comma_rd0",   obs(), ex(1, 0, 0, 1, 0, 1, 9'h1BC));
    send(10'h0B9); check("d0_0",        obs(), ex(1, 0, 0, 0, 0, 1, 9'h000));
    send(10'h283); check("disp_err",    obs(), ex(1, 0, 1, 1, 0, 1, 9'h1BC));
    repeat (4) send(10'h0B9);
    check("retire_clean", obs(), ex(1, 0, 0, 0, 0, 1, 9'h000));
    for (int i = 0; i < 4; i++) begin
      send(10'h000);
      check($sformatf("cerr%0d", i), obs(), ex(1, 1, 0, 0, 0, (i < 3), 9'h000));
    end

    send(10'h17C); send(10'h283); send(10'h17C);
    check("resync", obs(), ex(1, 0, 0, 1, 1, 1, 9'h1BC));
    repeat (3) send(10'h000);
    check("three_err", obs(), ex(1, 1, 0, 0, 1, 1, 9'h000));
    send(10'h283); send(10'h17C); send(10'h283); send(10'h17C);
    check("good_run", obs(), ex(1, 0, 0, 1, 1, 1, 9'h1BC));
    send(10'h000); check("retired_hold",  obs(), ex(1, 1, 0, 0, 1, 1, 9'h000));
    send(10'h000); check("drop_at_limit", obs(), ex(1, 1, 0, 0, 1, 0, 9'h000));

    send(10'h283); check("los_to_acq", obs(), ex(1, 0, 0, 1, 0, 0, 9'h1BC));
    idle(3);       check("gap_hold",   obs(), ex(0, 0, 0, 1, 0, 0, 9'h1BC));
    send(10'h17C); check("after_gap",  obs(), ex(1, 0, 0, 1, 1, 0, 9'h1BC));

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 10'h283;
    #2 rst_n = 1'b0;
    #1 check("async_rst", obs(), ex(0, 0, 0, 0, 0, 0, 9'h000));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1 check("drop_inflight", obs(), ex(0, 0, 0, 0, 0, 0, 9'h000));
    send(10'h17C); send(10'h283);
    check("cnt_cleared", obs(), ex(1, 0, 0, 1, 0, 0, 9'h1BC));
    send(10'h17C);
    check("resync2", obs(), ex(1, 0, 0, 1, 1, 1, 9'h1BC));

    for (int rdi = 0; rdi < 2; rdi++)
      for (int c = 0; c < 268; c++) begin
        code_of(c, k, b);
        encode(k, b, rdi[0], sym, rdo);
        legal_sym[sym] = 1'b1;
        set6[rev6(sym[5:0])] = 1'b1;
        set4[rev4(sym[9:6])] = 1'b1;
      end

    for (int rdi = 0; rdi < 2; rdi++)
      for (int c = 0; c < 268; c++) begin
        code_of(c, k, b);
        encode(k, b, rdi[0], sym, rdo);
        send(rdi[0] ? 10'h17C : 10'h283);
        send(sym);
        check($sformatf("leg_dat c%0d rd%0d", c, rdi), 32'(out_data), 32'({k, b}));
        check($sformatf("leg_err c%0d rd%0d", c, rdi), 32'({out_code_err, out_disp_err}), 32'd0);
        check($sformatf("leg_rd c%0d rd%0d", c, rdi), 32'(rd), 32'(rdo));
      end

    for (int rdi = 0; rdi < 2; rdi++)
      for (int s = 0; s < 1024; s++) begin
        sym  = 10'(s);
        s6   = rev6(sym[5:0]);
        s4   = rev4(sym[9:6]);
        k28f = (s6 == 6'b001111) || (s6 == 6'b110000);
        a7f  = (s4 == 4'b0111) || (s4 == 4'b1000);
        p7f  = (s4 == 4'b1110) || (s4 == 4'b0001);
        ill  = !set6[s6] || !set4[s4] || (k28f && p7f) || (a7f && !k28f && !legal_sym[sym]);
        if (ill || legal_sym[sym]) begin
          send(rdi[0] ? 10'h17C : 10'h283);
          send(sym);
          if (ill)
            check($sformatf("illegal 0x%03h rd%0d", s, rdi),
                  32'({out_code_err, out_disp_err, out_data}), 32'({1'b1, 1'b0, 9'h000}));
          else
            check($sformatf("legal_cerr 0x%03h rd%0d", s, rdi), 32'(out_code_err), 32'd0);
        end
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
